fifo_write_ctrl: RTL and testbench
==================================

FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 SHALL have parameter addr_size, default 3, log2 of FIFO depth (depth 8).
REQ-002 SHALL have parameter almost_full_thresh, default 6, minimum write_level at which almost_full asserts.
REQ-003 SHALL have port write_clk  input  1  write-domain clock.
REQ-004 SHALL have port write_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port write_en  input  1  write request from producer.
REQ-006 SHALL have port read_ptr_gray  input  addr_size+1  Gray read pointer, driven from the read_clk domain (asynchronous).
REQ-007 SHALL have port overflow_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port write_ptr_binary  output  addr_size  RAM write address.
REQ-009 SHALL have port write_ptr_gray  output  addr_size+1  registered Gray write pointer, sent to the read domain.
REQ-010 SHALL have port fifo_full  output  1  registered full flag, to RAM and producer.
REQ-011 SHALL have port almost_full  output  1  registered, write_level >= almost_full_thresh.
REQ-012 SHALL have port write_level  output  addr_size+1  registered pessimistic occupancy, 0..2^addr_size.
REQ-013 SHALL have port write_ack  output  1  combinational, write_en && !fifo_full.
REQ-014 SHALL have port overflow  output  1  sticky flag: write attempted while full.

Function
REQ-015 SHALL keep internal binary pointer wbin[addr_size:0]; wbin_next = wbin + write_ack, wrapping modulo 2^(addr_size+1).
REQ-016 SHALL drive write_ptr_binary = wbin[addr_size-1:0] and register write_ptr_gray = (wbin_next >> 1) ^ wbin_next.
REQ-017 SHALL change exactly one bit of write_ptr_gray per accepted write, including at wrap.
REQ-018 SHALL synchronise read_ptr_gray through two write_clk flops (rq1 -> rq2); no other logic SHALL use read_ptr_gray directly.
REQ-019 SHALL register fifo_full = (gray(wbin_next) == {~rq2[addr_size:addr_size-1], rq2[addr_size-2:0]}).
REQ-020 SHALL register write_level = wbin_next - gray2bin(rq2), modulo 2^(addr_size+1), at the same edge as fifo_full.
REQ-021 SHALL register almost_full from the same next-state level, so fifo_full implies almost_full.
REQ-022 SHALL assert fifo_full at the clock edge that accepts the write filling the last entry (no extra latency).
REQ-023 SHALL deassert fifo_full no earlier than the 3rd write_clk edge after read_ptr_gray changes (2 sync + 1 register).
REQ-024 SHALL ignore write_en while fifo_full: pointer, write_ptr_gray and write_level unchanged.
REQ-025 SHALL set overflow when write_en && fifo_full at an edge; overflow_clr clears it; simultaneous set and clear SHALL leave overflow = 1.

Reset
REQ-026 SHALL, on write_rst_n low, immediately and without a clock, clear wbin, rq1, rq2, write_ptr_gray, write_level and overflow to 0 and set fifo_full and almost_full to 0.
REQ-027 SHALL resume normal operation at the first write_clk edge after write_rst_n deasserts; a reset mid-burst discards all pointer state.

Structure
REQ-028 SHALL place bin-to-gray and gray-to-bin functions and the default address size in shared package fifo_pkg, reused by the read-side controller.
REQ-029 SHALL instantiate one sub-module, sync_2ff (parameterised width, async active-low reset), for the read pointer synchroniser.

Verification (addr_size=3, thresh=6)
REQ-030 SHALL check reset: assert write_rst_n low with no clock -> all outputs 0 immediately.
REQ-031 SHALL check fill: read_ptr_gray=0, 8 consecutive writes -> almost_full=1 after 6th edge, fifo_full=1 after 8th edge, write_ptr_binary=0, write_ptr_gray=4'b1100, write_level=8.
REQ-032 SHALL check overflow: write_en held 2 cycles while full -> pointers unchanged, overflow=1 and held; overflow_clr pulse -> overflow=0 next edge.
REQ-033 SHALL check drain: while full, set read_ptr_gray=4'b0001 -> fifo_full=0 and write_level=7 at the 3rd write_clk edge.
REQ-034 SHALL check wrap: 16 writes with read pointer tracking -> write_ptr_gray returns to 4'b0000, single-bit change on every step, fifo_full never asserts.
REQ-035 SHALL check mid-operation reset: assert write_rst_n during a burst -> outputs 0 asynchronously, first post-reset write gives write_ptr_binary=1 and write_ptr_gray=4'b0001.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer helpers and defaults for read/write controllers
package fifo_pkg;

    localparam int DEFAULT_ADDR_SIZE = 3;

    // Widest pointer the helpers handle; callers zero-extend into this and cast the result back.
    localparam int PTR_MAX_W = 16;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits of a zero-extended Gray value decode to zero, so one width serves all.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with asynchronous active-low reset
module sync_2ff #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage1;

    // First flop absorbs metastability, second presents a settled value to the domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - async FIFO write-side pointer, full/level and overflow control
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int addr_size          = DEFAULT_ADDR_SIZE,
    parameter int almost_full_thresh = 6
) (
    input  logic                 write_clk,
    input  logic                 write_rst_n,
    input  logic                 write_en,
    input  logic [addr_size:0]   read_ptr_gray,
    input  logic                 overflow_clr,
    output logic [addr_size-1:0] write_ptr_binary,
    output logic [addr_size:0]   write_ptr_gray,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic [addr_size:0]   write_level,
    output logic                 write_ack,
    output logic                 overflow
);

    localparam int ptr_w = addr_size + 1;
    localparam logic [ptr_w-1:0] thresh_level = ptr_w'(almost_full_thresh);

    logic [ptr_w-1:0] wbin;
    logic [ptr_w-1:0] wbin_next;
    logic [ptr_w-1:0] wgray_next;
    logic [ptr_w-1:0] rq2;
    logic [ptr_w-1:0] rbin;
    logic [ptr_w-1:0] full_pattern;
    logic [ptr_w-1:0] level_next;
    logic             full_next;
    logic             almost_next;

    // Read pointer crosses in here only; everything downstream uses rq2.
    sync_2ff #(
        .width(ptr_w)
    ) u_rptr_sync (
        .clk  (write_clk),
        .rst_n(write_rst_n),
        .d    (read_ptr_gray),
        .q    (rq2)
    );

    assign write_ack        = write_en && !fifo_full;
    assign write_ptr_binary = wbin[addr_size-1:0];

    // Next-state pointer and flags; flags look at the post-write pointer so full lands with the last write.
    always_comb begin
        wbin_next    = wbin + {{addr_size{1'b0}}, write_ack};
        wgray_next   = ptr_w'(bin2gray(PTR_MAX_W'(wbin_next)));
        rbin         = ptr_w'(gray2bin(PTR_MAX_W'(rq2)));
        full_pattern = {~rq2[addr_size:addr_size-1], rq2[addr_size-2:0]};
        full_next    = (wgray_next == full_pattern);
        level_next   = wbin_next - rbin;
        almost_next  = (level_next >= thresh_level);
    end

    // Pointer, Gray pointer and occupancy flags all update on the same edge.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            wbin           <= '0;
            write_ptr_gray <= '0;
            write_level    <= '0;
            fifo_full      <= 1'b0;
            almost_full    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            write_ptr_gray <= wgray_next;
            write_level    <= level_next;
            fifo_full      <= full_next;
            almost_full    <= almost_next;
        end
    end

    // Sticky overflow; a fresh rejected write wins over a clear in the same cycle.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            overflow <= 1'b0;
        end else if (write_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - directed self-checking bench for fifo_write_ctrl
`timescale 1ns/1ps
module tb_fifo_write_ctrl;

    logic       write_clk = 1'b0;
    logic       clk_run   = 1'b0;
    logic       write_rst_n;
    logic       write_en;
    logic [3:0] read_ptr_gray;
    logic       overflow_clr;
    logic [2:0] write_ptr_binary;
    logic [3:0] write_ptr_gray;
    logic       fifo_full;
    logic       almost_full;
    logic [3:0] write_level;
    logic       write_ack;
    logic       overflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    fifo_write_ctrl #(
        .addr_size         (3),
        .almost_full_thresh(6)
    ) dut (
        .write_clk       (write_clk),
        .write_rst_n     (write_rst_n),
        .write_en        (write_en),
        .read_ptr_gray   (read_ptr_gray),
        .overflow_clr    (overflow_clr),
        .write_ptr_binary(write_ptr_binary),
        .write_ptr_gray  (write_ptr_gray),
        .fifo_full       (fifo_full),
        .almost_full     (almost_full),
        .write_level     (write_level),
        .write_ack       (write_ack),
        .overflow        (overflow)
    );

    always #5 if (clk_run) write_clk = ~write_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample 1ns after the rising edge.
    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wbin"},  32'(write_ptr_binary), 32'd0);
        check_eq({tag, "_wgray"}, 32'(write_ptr_gray),   32'd0);
        check_eq({tag, "_full"},  32'(fifo_full),        32'd0);
        check_eq({tag, "_afull"}, 32'(almost_full),      32'd0);
        check_eq({tag, "_level"}, 32'(write_level),      32'd0);
        check_eq({tag, "_ovf"},   32'(overflow),         32'd0);
    endtask

    logic [3:0] exp_wbin;
    logic [3:0] prev_gray;

    initial begin
        write_rst_n   = 1'b1;
        write_en      = 1'b0;
        read_ptr_gray = 4'd0;
        overflow_clr  = 1'b0;

        // Reset with no clock running
        #2 write_rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        check_eq("reset_ack", 32'(write_ack), 32'd0);

        clk_run = 1'b1;
        tick();
        tick();
        write_rst_n = 1'b1;
        tick();

        // Fill: 8 writes into an empty FIFO
        write_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("fill_level_%0d", i), 32'(write_level), 32'(i));
            check_eq($sformatf("fill_afull_%0d", i), 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            check_eq($sformatf("fill_full_%0d", i),  32'(fifo_full),   (i == 8) ? 32'd1 : 32'd0);
        end
        check_eq("fill_wbin",  32'(write_ptr_binary), 32'd0);
        check_eq("fill_wgray", 32'(write_ptr_gray),   32'hC);
        check_eq("fill_ack",   32'(write_ack),        32'd0);
        check_eq("fill_ovf",   32'(overflow),         32'd0);

        // Overflow: write_en held two more cycles while full
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq($sformatf("ovf_wbin_%0d", i),  32'(write_ptr_binary), 32'd0);
            check_eq($sformatf("ovf_wgray_%0d", i), 32'(write_ptr_gray),   32'hC);
            check_eq($sformatf("ovf_level_%0d", i), 32'(write_level),      32'd8);
            check_eq($sformatf("ovf_flag_%0d", i),  32'(overflow),         32'd1);
        end
        write_en = 1'b0;
        tick();
        check_eq("ovf_hold", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        // Set and clear together: set wins
        write_en     = 1'b1;
        overflow_clr = 1'b1;
        tick();
        write_en     = 1'b0;
        overflow_clr = 1'b0;
        check_eq("ovf_set_clr", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("ovf_clr2", 32'(overflow), 32'd0);

        // Drain: one read seen from the read side, full drops at the 3rd edge
        read_ptr_gray = 4'b0001;
        tick();
        check_eq("drain_full_e1", 32'(fifo_full), 32'd1);
        tick();
        check_eq("drain_full_e2", 32'(fifo_full), 32'd1);
        tick();
        check_eq("drain_full_e3",  32'(fifo_full),   32'd0);
        check_eq("drain_level_e3", 32'(write_level), 32'd7);
        check_eq("drain_afull_e3", 32'(almost_full), 32'd1);

        // Reset back to empty before the wrap run
        write_rst_n   = 1'b0;
        read_ptr_gray = 4'd0;
        #1;
        check_all_zero("rst2");
        tick();
        write_rst_n = 1'b1;
        tick();

        // Wrap: 16 writes with the read pointer trailing the write pointer
        exp_wbin  = 4'd0;
        prev_gray = 4'd0;
        write_en  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_wbin = exp_wbin + 4'd1;
            check_eq($sformatf("wrap_gray_%0d", i), 32'(write_ptr_gray),   32'(gray4(exp_wbin)));
            check_eq($sformatf("wrap_bin_%0d", i),  32'(write_ptr_binary), 32'(exp_wbin[2:0]));
            check_eq($sformatf("wrap_step_%0d", i), 32'($countones(write_ptr_gray ^ prev_gray)), 32'd1);
            check_eq($sformatf("wrap_full_%0d", i), 32'(fifo_full),        32'd0);
            prev_gray     = write_ptr_gray;
            read_ptr_gray = gray4(exp_wbin);
        end
        check_eq("wrap_end_gray", 32'(write_ptr_gray), 32'h0);
        write_en = 1'b0;
        tick();
        tick();
        tick();

        // Mid-burst reset
        write_en = 1'b1;
        tick();
        tick();
        tick();
        #2 write_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        read_ptr_gray = 4'd0;
        write_en      = 1'b0;
        tick();
        #3 write_rst_n = 1'b1;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        check_eq("post_rst_bin",   32'(write_ptr_binary), 32'd1);
        check_eq("post_rst_gray",  32'(write_ptr_gray),   32'h1);
        check_eq("post_rst_level", 32'(write_level),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
